// File: rtl/ram_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_cmd_sequencer
// Purpose  : Command front-end for ram_sync. Buffers packed RAM command words
//            in a small in-order FIFO, issues them on ram_sync's
//            writeOn/address/data_in ports and returns read data on a
//            valid/ready response port.
//
// Ports    : clk, rst              - clock, synchronous active-high reset
//            cmd_valid/cmd_ready   - command handshake (cmd_ready = !full)
//            cmd_word              - {address, write flag, data}, MSB first
//            rd_valid/rd_ready     - read response handshake
//            rd_data               - read response data
//            busy                  - commands queued or a command in flight
//            writeOn/address/data_in - registered drive to ram_sync
//            data_out              - read data from ram_sync
//
// Revision : 1.0 - initial release
// ============================================================================
module ram_cmd_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,     // power of two, >= 2
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    // command port
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_W+DATA_W:0]     cmd_word,
    // read response port
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    // status
    output logic                       busy,
    // ram_sync side
    output logic                       writeOn,
    output logic [ADDR_W-1:0]          address,
    output logic [DATA_W-1:0]          data_in,
    input  logic [DATA_W-1:0]          data_out
);

    localparam int c_cmd_w  = ADDR_W + 1 + DATA_W;
    localparam int c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w  = c_ptr_w + 1;
    // Wait counter must reach RD_LAT+1.
    localparam int c_wait_w = $clog2(RD_LAT + 2);

    localparam logic [c_cnt_w-1:0]  c_full_count = c_cnt_w'(DEPTH);
    localparam logic [c_wait_w-1:0] c_wait_last  = c_wait_w'(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RD_RESP = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [c_cmd_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [c_cmd_w-1:0] w_head;
    logic [ADDR_W-1:0]  w_head_addr;
    logic               w_head_wr;
    logic [DATA_W-1:0]  w_head_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);
    // Readiness depends on fullness only, so a same-cycle pop never opens
    // the door for a push into a full FIFO.
    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_addr = w_head[c_cmd_w-1 -: ADDR_W];
    assign w_head_wr   = w_head[DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;

    logic w_clear_we;
    logic w_wait_inc;
    logic w_capture;
    logic w_release;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_clear_we  = 1'b0;
        w_wait_inc  = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            // IDLE and WR share the dispatch rule; chaining from WR gives
            // back-to-back writes at one per cycle.
            S_IDLE, S_WR: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head_wr ? S_WR : S_RD_WAIT;
                end else begin
                    w_clear_we  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            // The first wait cycle is the one in which the address is being
            // presented; RD_LAT+1 further cycles follow before capture, so
            // data_out is sampled well after it has settled.
            S_RD_WAIT: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RD_RESP;
                end else begin
                    w_wait_inc  = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (rd_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered RAM drive and read response
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            writeOn    <= 1'b0;
            address    <= '0;
            data_in    <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_pop) begin
                // Read commands still drive their data field onto data_in;
                // ram_sync ignores it while writeOn is low.
                address    <= w_head_addr;
                data_in    <= w_head_data;
                writeOn    <= w_head_wr;
                r_wait_cnt <= '0;
            end else if (w_clear_we) begin
                writeOn    <= 1'b0;
            end

            if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_capture) begin
                rd_data  <= data_out;
                rd_valid <= 1'b1;
            end else if (w_release) begin
                rd_valid <= 1'b0;
            end
        end
    end

    assign busy = ~w_empty | (r_state != S_IDLE);

endmodule
`default_nettype wire
